sdram_pixel_prefetch: RTL and testbench

SDRAM_PIXEL_PREFETCH -- requirements
Module: sdram_pixel_prefetch

---
 rtl/sdram_pixel_prefetch.sv | 238 +++++++++++++++++++++++
 tb/tb_sdram_pixel_prefetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pixel_prefetch.sv
// -----------------------------------------------------------------------------
// sdram_pixel_prefetch
//   Prefetches one video frame from SDRAM in 4-word bursts into a 16x16
//   show-ahead FIFO that feeds the TFT pixel timing stage.
//
//   Optional build macro: SDRAM_PREFETCH_UNDERRUN_CNT_EN
//     When defined, adds oUnderrun_Cnt, a saturating count of pops made
//     while the FIFO was empty (cleared by reset and by a frame restart).
//
// Parameters
//   BASE_ADDR    first SDRAM word address of the frame
//   FRAME_WORDS  16-bit words per frame (multiple of 4)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   en               fetch enable; gates new burst requests only
//   iFrame_Start     one-cycle pulse restarting the frame
//   oRd_Req          burst read request to the arbiter (held until done)
//   oRd_Addr         burst word address {bank, row, column}
//   iRd_Done         one-cycle burst completion from the arbiter
//   iRd_Data1..4     burst words, valid with iRd_Done
//   iPix_Rd          pixel pop strobe
//   oPix_Data        FIFO head word (combinational, show-ahead)
//   oPix_Valid       FIFO non-empty
//   oUnderflow       sticky: a pop arrived while the FIFO was empty
//   oFrame_Done      all FRAME_WORDS words of this frame fetched
//   oUnderrun_Cnt    (optional) saturating underflowing-pop count
// -----------------------------------------------------------------------------
module sdram_pixel_prefetch #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned FRAME_WORDS = 130560
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        iFrame_Start,
    output logic        oRd_Req,
    output logic [23:0] oRd_Addr,
    input  logic        iRd_Done,
    input  logic [15:0] iRd_Data1,
    input  logic [15:0] iRd_Data2,
    input  logic [15:0] iRd_Data3,
    input  logic [15:0] iRd_Data4,
    input  logic        iPix_Rd,
    output logic [15:0] oPix_Data,
    output logic        oPix_Valid,
    output logic        oUnderflow,
    output logic        oFrame_Done
`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0] oUnderrun_Cnt
`endif
);

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned PTR_W     = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BURST_LEN = 4;
    // A new burst fits only if four free slots remain.
    localparam logic [CNT_W-1:0]  CNT_REQ_MAX = CNT_W'(DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_LEN   = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BURST_STEP  = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   fetched_q;
    logic                pend_q;
    logic                frame_done_q;
    logic                underflow_q;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                restart_c;
    logic                push_c;
    logic                pop_req_c;
    logic                pop_c;
    logic                uflow_c;
    logic                last_burst_c;
    logic [WORD_W-1:0]   burst_c [BURST_LEN];

    // Burst words in FIFO write order.
    always_comb begin
        burst_c[0] = iRd_Data1;
        burst_c[1] = iRd_Data2;
        burst_c[2] = iRd_Data3;
        burst_c[3] = iRd_Data4;
    end

    // A restart seen during a burst (latched or arriving with iRd_Done) voids it.
    always_comb begin
        restart_c    = pend_q | iFrame_Start;
        push_c       = (state_q == REQ) & iRd_Done & ~restart_c;
        pop_req_c    = iPix_Rd & (state_q != FLUSH);
        pop_c        = pop_req_c & (count_q != '0);
        uflow_c      = pop_req_c & (count_q == '0);
        last_burst_c = (fetched_q + BURST_STEP) >= FRAME_LEN;
    end

    // Control FSM: request issue, burst completion, frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            addr_q       <= BASE_ADDR;
            fetched_q    <= '0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_q <= 1'b0;
                    if (iFrame_Start) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    addr_q       <= BASE_ADDR;
                    fetched_q    <= '0;
                    frame_done_q <= 1'b0;
                    pend_q       <= 1'b0;
                    req_q        <= 1'b0;
                    state_q      <= CHECK;
                end
                CHECK: begin
                    if (iFrame_Start) begin
                        state_q <= FLUSH;
                    end else if (fetched_q >= FRAME_LEN) begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (en && (count_q <= CNT_REQ_MAX)) begin
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (iRd_Done) begin
                        req_q  <= 1'b0;
                        pend_q <= 1'b0;
                        if (restart_c) begin
                            state_q <= FLUSH;
                        end else begin
                            fetched_q <= fetched_q + BURST_STEP;
                            // Address parks on the last burst of the frame.
                            if (!last_burst_c) begin
                                addr_q <= addr_q + BURST_STEP;
                            end
                            state_q <= CHECK;
                        end
                    end else if (iFrame_Start) begin
                        pend_q <= 1'b1;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage and pointers; 4-word push, 1-word pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                for (int i = 0; i < BURST_LEN; i++) begin
                    mem_q[wr_ptr_q + PTR_W'(i)] <= burst_c[i];
                end
                wr_ptr_q <= wr_ptr_q + PTR_W'(BURST_LEN);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q
                     + (push_c ? CNT_W'(BURST_LEN) : CNT_W'(0))
                     - (pop_c  ? CNT_W'(1)         : CNT_W'(0));
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (state_q == FLUSH) begin
            underflow_q <= 1'b0;
        end else if (uflow_c) begin
            underflow_q <= 1'b1;
        end
    end

`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    // Saturating count of underflowing pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_q <= '0;
        end else if (state_q == FLUSH) begin
            underrun_cnt_q <= '0;
        end else if (uflow_c && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign oUnderrun_Cnt = underrun_cnt_q;
`endif

    assign oRd_Req     = req_q;
    assign oRd_Addr    = addr_q;
    assign oPix_Data   = mem_q[rd_ptr_q];
    assign oPix_Valid  = (count_q != '0);
    assign oUnderflow  = underflow_q;
    assign oFrame_Done = frame_done_q;

endmodule

// File: tb/tb_sdram_pixel_prefetch.sv
// -----------------------------------------------------------------------------
// tb_sdram_pixel_prefetch
//   Directed scenarios with literal expectations, then a long randomized run.
//   A queue-based frame model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_sdram_pixel_prefetch;

    localparam logic [23:0] BASE = 24'h000040;
    localparam int          FW   = 32;

    logic        clk = 1'b0;
    logic        rst_n, en, start, done, pix_rd;
    logic [15:0] d1, d2, d3, d4;
    logic        req, pix_valid, uf, fdone;
    logic [23:0] addr;
    logic [15:0] pix;
`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    always #5 clk = ~clk;

    sdram_pixel_prefetch #(.BASE_ADDR(BASE), .FRAME_WORDS(FW)) dut (
`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
        .oUnderrun_Cnt(ucnt),
`endif
        .clk(clk), .rst_n(rst_n), .en(en), .iFrame_Start(start),
        .oRd_Req(req), .oRd_Addr(addr), .iRd_Done(done),
        .iRd_Data1(d1), .iRd_Data2(d2), .iRd_Data3(d3), .iRd_Data4(d4),
        .iPix_Rd(pix_rd), .oPix_Data(pix), .oPix_Valid(pix_valid),
        .oUnderflow(uf), .oFrame_Done(fdone)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    // phase: 0 idle, 1 check, 2 burst outstanding, 3 flush
    int          m_phase;
    logic        m_req, m_fdone, m_pend, m_uf;
    logic [23:0] m_addr;
    int          m_fetched, m_ucnt;
    logic [15:0] m_q[$];

    always @(posedge clk or negedge rst_n) begin
        int  n0;
        logic restart;
        if (!rst_n) begin
            m_phase = 0; m_req = 0; m_fdone = 0; m_pend = 0; m_uf = 0;
            m_addr = BASE; m_fetched = 0; m_ucnt = 0; m_q.delete();
        end else begin
            n0 = m_q.size();
            restart = m_pend || start;
            if (m_phase == 3) begin
                m_q.delete(); m_uf = 0; m_ucnt = 0;
            end else begin
                if (pix_rd) begin
                    if (n0 == 0) begin
                        m_uf = 1;
                        if (m_ucnt < 65535) m_ucnt++;
                    end else begin
                        void'(m_q.pop_front());
                    end
                end
                if (m_phase == 2 && done && !restart) begin
                    m_q.push_back(d1); m_q.push_back(d2);
                    m_q.push_back(d3); m_q.push_back(d4);
                end
            end
            case (m_phase)
                0: if (start) m_phase = 3;
                3: begin
                    m_addr = BASE; m_fetched = 0; m_fdone = 0; m_pend = 0; m_req = 0;
                    m_phase = 1;
                end
                1: begin
                    if (start) m_phase = 3;
                    else if (m_fetched == FW) begin m_fdone = 1; m_phase = 0; end
                    else if (en && n0 + 4 <= 16) begin m_req = 1; m_phase = 2; end
                end
                default: begin
                    if (done) begin
                        m_req = 0; m_pend = 0;
                        if (restart) m_phase = 3;
                        else begin
                            m_fetched += 4;
                            if (m_fetched < FW) m_addr = m_addr + 24'd4;
                            m_phase = 1;
                        end
                    end else if (start) m_pend = 1;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare and request log ----------------
    logic [23:0] req_log[$];
    logic        prev_req = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("rd_req", 32'(req), 32'(m_req));
            chk("rd_addr", 32'(addr), 32'(m_addr));
            chk("pix_valid", 32'(pix_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("pix_data", 32'(pix), 32'(m_q[0]));
            chk("underflow", 32'(uf), 32'(m_uf));
            chk("frame_done", 32'(fdone), 32'(m_fdone));
`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
            chk("underrun_cnt", 32'(ucnt), 32'(m_ucnt));
`endif
            if (req && !prev_req) req_log.push_back(addr);
            prev_req = req;
        end
    end

    // ---------------- arbiter model ----------------
    bit arb_on = 1, spur_on = 0, rnd_data = 0, man_done = 0;
    int arb_lat = 6, wcnt = 0, seq = 0;

    task automatic set_data();
        logic [15:0] w[4];
        for (int k = 0; k < 4; k++) begin
            w[k] = rnd_data ? 16'($urandom) : 16'hA000 + 16'(seq);
            seq++;
        end
        d1 = w[0]; d2 = w[1]; d3 = w[2]; d4 = w[3];
    endtask

    initial begin
        done = 0; d1 = 0; d2 = 0; d3 = 0; d4 = 0;
        forever begin
            @(negedge clk);
            #1;
            done = 1'b0;
            if (man_done) begin
                done = 1'b1; set_data();
            end else if (arb_on) begin
                if (req && rst_n) begin
                    wcnt++;
                    if (wcnt >= arb_lat) begin
                        done = 1'b1; set_data(); wcnt = 0;
                        arb_lat = rnd_data ? $urandom_range(1, 8) : 6;
                    end
                end else begin
                    wcnt = 0;
                end
                if (!done && spur_on && $urandom_range(0, 59) == 0) begin
                    done = 1'b1; set_data();
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int i0;
        int pop_pct;
        rst_n = 0; en = 0; start = 0; pix_rd = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", 32'(addr), 32'(BASE));
        chk("rst_pix_data", 32'(pix), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_fdone", 32'(fdone), 32'd0);

        // pop while empty
        pix_rd = 1; @(negedge clk); pix_rd = 0; @(negedge clk);
        chk("uflow_flag", 32'(uf), 32'd1);
        chk("uflow_valid", 32'(pix_valid), 32'd0);
`ifdef SDRAM_PREFETCH_UNDERRUN_CNT_EN
        chk("uflow_cnt", 32'(ucnt), 32'd1);
`endif

        // four bursts fill the FIFO, fifth is held
        i0 = req_log.size();
        en = 1; start = 1; @(negedge clk); start = 0;
        repeat (120) @(negedge clk);
        chk("fill_nreq", 32'(req_log.size() - i0), 32'd4);
        for (int k = 0; k < 4 && i0 + k < req_log.size(); k++)
            chk("fill_addr", 32'(req_log[i0+k]), 32'(BASE + 24'(4*k)));
        chk("fill_uflow_cleared", 32'(uf), 32'd0);
        chk("fill_held", 32'(req), 32'd0);

        // drain in order
        en = 0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_word", 32'(pix), 32'(16'hA000 + 16'(k)));
            pix_rd = 1; @(negedge clk); pix_rd = 0;
        end
        chk("drain_empty", 32'(pix_valid), 32'd0);

        // count 12: push and pop in the same cycle
        en = 1;
        for (int t = 0; t < 300 && req_log.size() < 8; t++) @(negedge clk);
        chk("c12_nreq", 32'(req_log.size()), 32'd8);
        arb_on = 0;
        repeat (2) @(negedge clk);
        man_done = 1; pix_rd = 1; @(negedge clk); man_done = 0; pix_rd = 0; en = 0;
        chk("c12_head", 32'(pix), 32'h0000A011);
        for (int k = 0; k < 15; k++) begin
            chk("c12_word", 32'(pix), 32'(16'hA011 + 16'(k)));
            pix_rd = 1; @(negedge clk); pix_rd = 0;
        end
        chk("c12_empty", 32'(pix_valid), 32'd0);
        chk("frame_done", 32'(fdone), 32'd1);
        chk("last_addr", 32'(req_log[7]), 32'(BASE + 24'd28));
        repeat (10) @(negedge clk);
        chk("no_req_after_frame", 32'(req_log.size()), 32'd8);

        // restart during burst at offset 8
        arb_on = 1; en = 1;
        i0 = req_log.size();
        start = 1; @(negedge clk); start = 0;
        for (int t = 0; t < 200 && req_log.size() < i0 + 3; t++) @(negedge clk);
        chk("rs_nreq", 32'(req_log.size() - i0), 32'd3);
        if (req_log.size() >= i0 + 3)
            chk("rs_addr8", 32'(req_log[i0+2]), 32'(BASE + 24'd8));
        start = 1; @(negedge clk); start = 0;
        for (int t = 0; t < 200 && req_log.size() < i0 + 4; t++) @(negedge clk);
        chk("rs_nreq2", 32'(req_log.size() - i0), 32'd4);
        if (req_log.size() >= i0 + 4)
            chk("rs_addr_base", 32'(req_log[i0+3]), 32'(BASE));
        chk("rs_empty", 32'(pix_valid), 32'd0);

        // reset with a request outstanding, then a stray done
        arb_on = 0;
        i0 = req_log.size();
        @(negedge clk);
        rst_n = 0; @(negedge clk);
        chk("rmid_req", 32'(req), 32'd0);
        rst_n = 1; @(negedge clk);
        man_done = 1; @(negedge clk); man_done = 0;
        repeat (3) @(negedge clk);
        chk("rmid_req2", 32'(req), 32'd0);
        chk("rmid_valid", 32'(pix_valid), 32'd0);
        chk("rmid_nreq", 32'(req_log.size()), 32'(i0));

        // randomized run
        arb_on = 1; spur_on = 1; rnd_data = 1; pop_pct = 50;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (c % 2000 == 0) pop_pct = $urandom_range(10, 90);
            rst_n  = ($urandom_range(0, 3999) != 0);
            en     = ($urandom_range(0, 7) != 0);
            start  = ($urandom_range(0, 149) == 0);
            pix_rd = ($urandom_range(0, 99) < pop_pct);
        end
        @(negedge clk);
        rst_n = 1; start = 0; pix_rd = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
